// File: rtl/prog_loader.sv
// UART program loader: waits for a sync byte, then assembles big-endian words
// into consecutive instruction-memory addresses until a zero word, overflow or timeout.
module prog_loader #(
    parameter int          WORD_BYTES  = 4,
    parameter int          ADDR_W      = 8,
    parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
    parameter int          TIMEOUT_CYC = 0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    input  logic                    reload,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [8*WORD_BYTES-1:0] wr_data,
    output logic                    busy,
    output logic                    run,
    output logic                    done,
    output logic                    err_overflow,
    output logic                    err_timeout,
    output logic [ADDR_W:0]         word_count
);

    localparam int W     = 8 * WORD_BYTES;
    localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic [1:0]        state;
    logic [IDX_W-1:0]  byte_idx;
    logic [ADDR_W-1:0] word_addr;
    logic [W-1:0]      word_buf;
    logic [W-1:0]      word_next;
    logic [TO_W-1:0]   to_cnt;
    logic              last_byte;
    logic              timed_out;

    // Incoming byte shifts in at the bottom, so the first byte ends up as the MSB.
    assign word_next = (word_buf << 8) | W'(rx_data);
    assign last_byte = (byte_idx == IDX_W'(WORD_BYTES - 1));
    assign timed_out = (TIMEOUT_CYC > 0) && (to_cnt == TO_W'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            byte_idx     <= '0;
            word_addr    <= '0;
            word_buf     <= '0;
            to_cnt       <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            busy         <= 1'b0;
            run          <= 1'b0;
            done         <= 1'b0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
            word_count   <= '0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            if (reload) begin
                state        <= S_IDLE;
                byte_idx     <= '0;
                word_addr    <= '0;
                word_buf     <= '0;
                to_cnt       <= '0;
                wr_addr      <= '0;
                wr_data      <= '0;
                busy         <= 1'b0;
                run          <= 1'b0;
                err_overflow <= 1'b0;
                err_timeout  <= 1'b0;
                word_count   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (rx_valid && rx_data == SYNC_BYTE) begin
                            state      <= S_LOAD;
                            busy       <= 1'b1;
                            byte_idx   <= '0;
                            word_addr  <= '0;
                            word_buf   <= '0;
                            to_cnt     <= '0;
                            word_count <= '0;
                        end
                    end
                    S_LOAD: begin
                        if (rx_valid) begin
                            to_cnt   <= '0;
                            word_buf <= word_next;
                            if (last_byte) begin
                                byte_idx   <= '0;
                                wr_en      <= 1'b1;
                                wr_addr    <= word_addr;
                                wr_data    <= word_next;
                                word_count <= word_count + 1'b1;
                                // Terminator check wins over overflow so a zero word in the last slot still runs.
                                if (word_next == '0) begin
                                    state <= S_RUN;
                                    busy  <= 1'b0;
                                    run   <= 1'b1;
                                    done  <= 1'b1;
                                end else if (word_addr == '1) begin
                                    state        <= S_ERR;
                                    busy         <= 1'b0;
                                    err_overflow <= 1'b1;
                                end else begin
                                    word_addr <= word_addr + 1'b1;
                                end
                            end else begin
                                byte_idx <= byte_idx + 1'b1;
                            end
                        end else if (timed_out) begin
                            state       <= S_ERR;
                            busy        <= 1'b0;
                            err_timeout <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: three instances cover default, small-address
// with timeout, and two-byte-word configurations; writes are checked against a scoreboard.
module tb_prog_loader;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] rx_data [3];
    logic       rx_valid [3];
    logic       reload [3];

    logic        wr_en0, busy0, run0, done0, ovf0, tmo0;
    logic [7:0]  wr_addr0;
    logic [31:0] wr_data0;
    logic [8:0]  wc0;

    logic        wr_en1, busy1, run1, done1, ovf1, tmo1;
    logic [1:0]  wr_addr1;
    logic [31:0] wr_data1;
    logic [2:0]  wc1;

    logic        wr_en2, busy2, run2, done2, ovf2, tmo2;
    logic [7:0]  wr_addr2;
    logic [15:0] wr_data2;
    logic [8:0]  wc2;

    prog_loader dut0 (
        .clk(clk), .rstn(rstn), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .reload(reload[0]),
        .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0), .busy(busy0), .run(run0),
        .done(done0), .err_overflow(ovf0), .err_timeout(tmo0), .word_count(wc0)
    );

    prog_loader #(.ADDR_W(2), .TIMEOUT_CYC(10)) dut1 (
        .clk(clk), .rstn(rstn), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .reload(reload[1]),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .busy(busy1), .run(run1),
        .done(done1), .err_overflow(ovf1), .err_timeout(tmo1), .word_count(wc1)
    );

    prog_loader #(.WORD_BYTES(2)) dut2 (
        .clk(clk), .rstn(rstn), .rx_data(rx_data[2]), .rx_valid(rx_valid[2]), .reload(reload[2]),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2), .busy(busy2), .run(run2),
        .done(done2), .err_overflow(ovf2), .err_timeout(tmo2), .word_count(wc2)
    );

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic        dn;
        logic        rn;
        logic        ov;
        logic [63:0] wc;
    } exp_t;

    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];
    exp_t e0, e1, e2;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic pushExp(input int inst, input int addr, input logic [31:0] data,
                           input logic dn, input logic rn, input logic ov, input int wc);
        exp_t e;
        e.addr = 64'(addr);
        e.data = 64'(data);
        e.dn   = dn;
        e.rn   = rn;
        e.ov   = ov;
        e.wc   = 64'(wc);
        case (inst)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Called #1 after a rising edge; leaves the strobe up for exactly one edge.
    task automatic applyStimulus(input int inst, input logic [7:0] b);
        rx_data[inst]  = b;
        rx_valid[inst] = 1'b1;
        @(posedge clk);
        #1;
        rx_valid[inst] = 1'b0;
    endtask

    task automatic sendWord(input int inst, input logic [31:0] w, input int nbytes);
        for (int i = nbytes - 1; i >= 0; i--) begin
            applyStimulus(inst, w[8*i +: 8]);
        end
    endtask

    task automatic pulseReload(input int inst, input logic with_byte);
        reload[inst]   = 1'b1;
        rx_valid[inst] = with_byte;
        rx_data[inst]  = 8'hAA;
        @(posedge clk);
        #1;
        reload[inst]   = 1'b0;
        rx_valid[inst] = 1'b0;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rstn && wr_en0) begin
            if (q0.size() == 0) begin
                checkOutput("inst0_spurious_wr", 64'(wr_en0), 64'd0);
            end else begin
                e0 = q0.pop_front();
                checkOutput("inst0_wr_addr", 64'(wr_addr0), e0.addr);
                checkOutput("inst0_wr_data", 64'(wr_data0), e0.data);
                checkOutput("inst0_done", 64'(done0), 64'(e0.dn));
                checkOutput("inst0_run", 64'(run0), 64'(e0.rn));
                checkOutput("inst0_ovf", 64'(ovf0), 64'(e0.ov));
                checkOutput("inst0_wc", 64'(wc0), e0.wc);
            end
        end
    end

    always @(negedge clk) begin
        if (rstn && wr_en1) begin
            if (q1.size() == 0) begin
                checkOutput("inst1_spurious_wr", 64'(wr_en1), 64'd0);
            end else begin
                e1 = q1.pop_front();
                checkOutput("inst1_wr_addr", 64'(wr_addr1), e1.addr);
                checkOutput("inst1_wr_data", 64'(wr_data1), e1.data);
                checkOutput("inst1_done", 64'(done1), 64'(e1.dn));
                checkOutput("inst1_run", 64'(run1), 64'(e1.rn));
                checkOutput("inst1_ovf", 64'(ovf1), 64'(e1.ov));
                checkOutput("inst1_wc", 64'(wc1), e1.wc);
            end
        end
    end

    always @(negedge clk) begin
        if (rstn && wr_en2) begin
            if (q2.size() == 0) begin
                checkOutput("inst2_spurious_wr", 64'(wr_en2), 64'd0);
            end else begin
                e2 = q2.pop_front();
                checkOutput("inst2_wr_addr", 64'(wr_addr2), e2.addr);
                checkOutput("inst2_wr_data", 64'(wr_data2), e2.data);
                checkOutput("inst2_done", 64'(done2), 64'(e2.dn));
                checkOutput("inst2_run", 64'(run2), 64'(e2.rn));
                checkOutput("inst2_ovf", 64'(ovf2), 64'(e2.ov));
                checkOutput("inst2_wc", 64'(wc2), e2.wc);
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 3; i++) begin
            rx_data[i]  = 8'h00;
            rx_valid[i] = 1'b0;
            reload[i]   = 1'b0;
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_wr_en", 64'(wr_en0), 64'd0);
        checkOutput("rst_wr_data", 64'(wr_data0), 64'd0);
        checkOutput("rst_busy", 64'(busy0), 64'd0);
        checkOutput("rst_run", 64'(run0), 64'd0);
        checkOutput("rst_done", 64'(done0), 64'd0);
        checkOutput("rst_flags", 64'({ovf0, tmo0}), 64'd0);
        checkOutput("rst_wc", 64'(wc0), 64'd0);
        rstn = 1'b1;
        stepCycle();

        $display("[TB] basic load");
        applyStimulus(0, 8'hAA);
        checkOutput("s1_busy_after_sync", 64'(busy0), 64'd1);
        pushExp(0, 0, 32'h20080005, 1'b0, 1'b0, 1'b0, 1);
        sendWord(0, 32'h20080005, 4);
        pushExp(0, 1, 32'h0, 1'b1, 1'b1, 1'b0, 2);
        sendWord(0, 32'h0, 4);
        stepCycle();
        checkOutput("s1_done_one_cycle", 64'(done0), 64'd0);
        checkOutput("s1_run", 64'(run0), 64'd1);
        checkOutput("s1_busy_off", 64'(busy0), 64'd0);
        checkOutput("s1_wc", 64'(wc0), 64'd2);

        $display("[TB] reload with simultaneous sync byte");
        pulseReload(0, 1'b1);
        checkOutput("s5_reload_run", 64'(run0), 64'd0);
        checkOutput("s5_reload_busy", 64'(busy0), 64'd0);
        checkOutput("s5_reload_wc", 64'(wc0), 64'd0);
        sendWord(0, 32'h0, 4);
        checkOutput("s5_dropped_sync_busy", 64'(busy0), 64'd0);
        checkOutput("s5_dropped_sync_run", 64'(run0), 64'd0);

        $display("[TB] ignored bytes");
        applyStimulus(0, 8'h55);
        applyStimulus(0, 8'h13);
        checkOutput("s2_idle_busy", 64'(busy0), 64'd0);
        applyStimulus(0, 8'hAA);
        pushExp(0, 0, 32'h0, 1'b1, 1'b1, 1'b0, 1);
        sendWord(0, 32'h0, 4);
        applyStimulus(0, 8'hAA);
        sendWord(0, 32'h0, 4);
        checkOutput("s2_run_hold", 64'(run0), 64'd1);
        checkOutput("s2_wc_hold", 64'(wc0), 64'd1);

        $display("[TB] overflow");
        applyStimulus(1, 8'hAA);
        for (int a = 0; a < 4; a++) begin
            pushExp(1, a, 32'h1000_0001 + 32'(a) * 32'h0101_0101, 1'b0, 1'b0, (a == 3), a + 1);
            sendWord(1, 32'h1000_0001 + 32'(a) * 32'h0101_0101, 4);
        end
        stepCycle();
        checkOutput("s3_ovf", 64'(ovf1), 64'd1);
        checkOutput("s3_run", 64'(run1), 64'd0);
        checkOutput("s3_busy", 64'(busy1), 64'd0);
        checkOutput("s3_wc", 64'(wc1), 64'd4);
        sendWord(1, 32'h0, 4);
        sendWord(1, 32'hAA11_2233, 4);
        checkOutput("s3_wc_hold", 64'(wc1), 64'd4);
        checkOutput("s3_tmo_clear", 64'(tmo1), 64'd0);
        pulseReload(1, 1'b0);
        checkOutput("s3_reload_ovf", 64'(ovf1), 64'd0);
        checkOutput("s3_reload_wc", 64'(wc1), 64'd0);

        $display("[TB] timeout");
        applyStimulus(1, 8'hAA);
        applyStimulus(1, 8'h12);
        applyStimulus(1, 8'h34);
        n = 0;
        while (!tmo1 && n < 50) begin
            stepCycle();
            n++;
        end
        checkOutput("s4_timeout_latency", 64'(n), 64'd11);
        checkOutput("s4_wc", 64'(wc1), 64'd0);
        checkOutput("s4_busy", 64'(busy1), 64'd0);

        $display("[TB] two-byte words");
        applyStimulus(2, 8'hAA);
        pushExp(2, 0, 32'h0000_ABCD, 1'b0, 1'b0, 1'b0, 1);
        sendWord(2, 32'h0000_ABCD, 2);
        pushExp(2, 1, 32'h0, 1'b1, 1'b1, 1'b0, 2);
        sendWord(2, 32'h0, 2);
        stepCycle();
        checkOutput("s6_done_one_cycle", 64'(done2), 64'd0);
        checkOutput("s6_run", 64'(run2), 64'd1);

        $display("[TB] async reset mid-load");
        pulseReload(0, 1'b0);
        applyStimulus(0, 8'hAA);
        sendWord(0, 32'h1122_3344, 4);
        checkOutput("s5_wr_in_flight", 64'(wr_en0), 64'd1);
        rstn = 1'b0;
        #1;
        checkOutput("s5_rst_wr_en", 64'(wr_en0), 64'd0);
        checkOutput("s5_rst_wr_data", 64'(wr_data0), 64'd0);
        checkOutput("s5_rst_busy", 64'(busy0), 64'd0);
        checkOutput("s5_rst_wc", 64'(wc0), 64'd0);
        checkOutput("s5_rst_run2", 64'(run2), 64'd0);
        checkOutput("s5_rst_tmo1", 64'(tmo1), 64'd0);
        repeat (2) @(posedge clk);
        #1;

        checkOutput("q0_drained", 64'(q0.size()), 64'd0);
        checkOutput("q1_drained", 64'(q1.size()), 64'd0);
        checkOutput("q2_drained", 64'(q2.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Parametrised UART program loader that replaces the hard-wired LOAD mode of the single-cycle core. It watches the byte stream from `uart_rx` for a sync byte, then assembles `WORD_BYTES`-wide big-endian words into consecutive instruction-memory addresses. Loading ends at the first all-zero word, on overflow, or on an inter-byte timeout. It reports `run` to release the core into execution and supports reload without a full reset.

## Interface

Parameters:
- `WORD_BYTES`, default 4: bytes per instruction word.
- `ADDR_W`, default 8: word-address width; memory depth is 2^ADDR_W words.
- `SYNC_BYTE`, default 8'hAA: byte that starts a load.
- `TIMEOUT_CYC`, default 0: maximum idle cycles between bytes in LOAD. A value of 0 disables the timeout.

Ports:
- `clk`, input, 1: single clock.
- `rstn`, input, 1: reset, asynchronous and active-low.
- `rx_data`, input, 8: received byte.
- `rx_valid`, input, 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `reload`, input, 1: one-cycle pulse; returns the block to IDLE from any state.
- `wr_en`, output, 1: one-cycle memory write strobe.
- `wr_addr`, output, ADDR_W: word address for the write.
- `wr_data`, output, 8*WORD_BYTES: assembled word.
- `busy`, output, 1: high while in LOAD.
- `run`, output, 1: high while in RUN; the core executes only when this is high.
- `done`, output, 1: one-cycle pulse on entry to RUN.
- `err_overflow`, output, 1: sticky; set on entry to ERR via overflow.
- `err_timeout`, output, 1: sticky; set on entry to ERR via timeout.
- `word_count`, output, ADDR_W+1: number of words written in the current or last load, including the terminator.

## Operation

States are IDLE, LOAD, RUN and ERR. Reset state is IDLE.

- **IDLE**
  - `rx_valid` with `rx_data == SYNC_BYTE`: go to LOAD; clear `word_count`, byte index and word address.
  - Any other byte is ignored.
- **LOAD**
  - Each `rx_valid` shifts `rx_data` into the word buffer, MSB first. The first byte lands in bits [8*WORD_BYTES-1 -: 8].
  - A byte equal to `SYNC_BYTE` is treated as ordinary data.
  - The byte index counts 0..WORD_BYTES-1 and wraps to 0 after the last byte.
  - When the last byte of a word arrives:
    - Write the word at the current word address; increment `word_count`.
    - If the word is all-zero, go to RUN.
    - Otherwise, if the word address is 2^ADDR_W-1, go to ERR and set `err_overflow`.
    - Otherwise, increment the word address and stay in LOAD.
  - Timeout (only when TIMEOUT_CYC > 0):
    - A counter resets on every `rx_valid` and on entry to LOAD, and increments every other cycle.
    - When it reaches TIMEOUT_CYC, go to ERR and set `err_timeout`.
    - Any partial word is discarded and not written.
- **RUN**: all bytes are ignored, including `SYNC_BYTE`. `word_count` holds its value.
- **ERR**: all bytes are ignored. Error flags and `word_count` hold their values.
- **reload** (any state): go to IDLE and clear the error flags, `word_count` and byte index. It takes priority over a simultaneous `rx_valid`; that byte is dropped.
- **Arithmetic**: the word address is ADDR_W bits and never wraps, because overflow is detected first. `word_count` is ADDR_W+1 bits, so it can reach 2^ADDR_W.

## Timing

- **Reset values**: all outputs are 0, `wr_data` is 0, and state is IDLE.
- **Asynchronous reset mid-load**: any partial word is lost, and any `wr_en` in flight is cleared immediately.
- **Registered outputs**: all outputs are registered.
- **Write latency**: `wr_en`, `wr_addr` and `wr_data` are valid in the cycle after the `rx_valid` of a word's last byte. `wr_en` is high for exactly one cycle.
- **Terminator**: `done` pulses and `run` rises in the same cycle as the terminator's `wr_en`. `word_count` already includes the terminator in that cycle.
- **Overflow**: `err_overflow` rises in the same cycle as the overflowing word's `wr_en`.
- **Timeout**: `err_timeout` rises TIMEOUT_CYC+1 cycles after the last `rx_valid`, or after LOAD entry if no byte has arrived.
- **`busy`**: high from the cycle after the sync byte until the cycle of the state exit.
- **Throughput**: back-to-back `rx_valid` strobes on consecutive cycles are accepted without loss.
- **`reload`**: takes effect on the next edge; all outputs are IDLE values one cycle later.

## Test plan

1. **Basic load** (defaults): send AA, 20 08 00 05, 00 00 00 00 -> `wr_en` at addr 0 data 32'h20080005, then addr 1 data 0. `done` pulses with `run`=1 and `word_count`=2.
2. **Ignored bytes**: send 55, 13, AA, 00 00 00 00 -> 55 and 13 are ignored. Single write at addr 0 data 0, `word_count`=1, `run`=1. A further AA in RUN causes no write.
3. **Overflow** (ADDR_W=2): send AA then four nonzero words -> writes at addrs 0-3. ERR with `err_overflow`=1 in the cycle of the addr-3 write, `word_count`=4, `run`=0. Later bytes are ignored.
4. **Timeout** (TIMEOUT_CYC=10): send AA, 12 34, then idle -> no write. `err_timeout`=1 exactly 11 cycles after the 34 strobe.
5. **Reload and reset**: after scenario 1, pulse `reload` together with `rx_valid`=AA -> state IDLE, byte dropped. Next AA plus a zero word loads again. Then assert `rstn` low mid-word -> all outputs 0 immediately.
6. **WORD_BYTES=2**: send AA, AB CD, 00 00 -> write 16'hABCD at addr 0, then 0 at addr 1. `done` pulses.
